// File: rtl/iccm_arbiter.sv
// Two-port arbiter for the single-port ICCM: fetch (A, read-only) and loader (B, read/write).
// A-priority with a streak limit, BOOT hold for fetch, and one-cycle read-return routing.
module iccm_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4,
  parameter int BOOT_HOLD  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  boot_done,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [3:0]            b_wmask,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  boot_state,
  output logic                  err
);

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e     state_q;
  logic [3:0] streak_q, streak_d;
  logic       pend_q, pend_d;
  logic       owner_q, owner_d;
  logic       wack_q, wack_d;
  logic       err_q;
  logic       contested;
  logic       fwd;

  // Grants are suppressed while reset is held so nothing new enters flight.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    contested = a_req & b_req;
    if (!reset) begin
      if (state_q == ST_BOOT) begin
        b_gnt = b_req;
      end else if (contested) begin
        if (streak_q == STREAK_MAX) b_gnt = 1'b1;
        else                        a_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    streak_d = 4'd0;
    if (a_gnt && contested) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    end
    pend_d  = a_gnt | (b_gnt & ~b_we);
    owner_d = b_gnt;
    wack_d  = b_gnt & b_we;
  end

  assign mem_req   = a_gnt | b_gnt;
  assign mem_we    = b_gnt & b_we;
  assign mem_addr  = b_gnt ? b_addr : a_addr;
  assign mem_wdata = b_gnt ? b_wdata : '0;
  assign mem_wmask = b_gnt ? b_wmask : 4'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= (BOOT_HOLD != 0) ? ST_BOOT : ST_RUN;
      streak_q <= 4'd0;
      pend_q   <= 1'b0;
      owner_q  <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_BOOT && boot_done) state_q <= ST_RUN;
      streak_q <= streak_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      wack_q   <= wack_d;
      if (mem_rvalid && !pend_q) err_q <= 1'b1;
    end
  end

  // Read return: valid only for the owner of the read issued last cycle.
  assign fwd        = ~reset & pend_q & mem_rvalid;
  assign a_rvalid   = fwd & ~owner_q;
  assign a_rdata    = a_rvalid ? mem_rdata : '0;
  assign b_rvalid   = (fwd & owner_q) | (~reset & wack_q);
  assign b_rdata    = (fwd & owner_q) ? mem_rdata : '0;
  assign boot_state = (state_q == ST_BOOT);
  assign err        = err_q;

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter with a small one-cycle-latency ICCM model.
module tb_iccm_arbiter;

  logic        clk = 1'b0;
  logic        reset, boot_done;
  logic        a_req, a_gnt, a_rvalid;
  logic [11:0] a_addr;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic [11:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_wmask;
  logic        mem_req, mem_we, mem_rvalid;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        boot_state, err;

  logic        mdl_rvalid = 1'b0;
  logic [31:0] mdl_rdata  = '0;
  logic        inj;
  logic [31:0] mem [0:4095];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iccm_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_STREAK(4), .BOOT_HOLD(1)) dut (
    .clock(clk), .reset(reset), .boot_done(boot_done),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .boot_state(boot_state), .err(err)
  );

  // ICCM model: masked writes, reads return one cycle after acceptance.
  always @(posedge clk) begin
    mdl_rvalid <= mem_req && !mem_we;
    mdl_rdata  <= mem[mem_addr];
    if (mem_req && mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_wmask[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  assign mem_rvalid = mdl_rvalid | inj;
  assign mem_rdata  = mdl_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    reset = 1'b1; boot_done = 1'b0; inj = 1'b0;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    tick(); tick();
    reset = 1'b0;
    #4;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_boot_state", {31'd0, boot_state}, 32'd1);

    // Fetch held off while in BOOT.
    tick();
    a_req = 1'b1; a_addr = 12'h010;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("boot_a_gnt", {31'd0, a_gnt}, 32'd0);
      chk("boot_mem_req", {31'd0, mem_req}, 32'd0);
      chk("boot_state_hold", {31'd0, boot_state}, 32'd1);
      tick();
    end
    a_req = 1'b0;

    // Loader write during BOOT.
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h004; b_wdata = 32'hDEAD_BEEF; b_wmask = 4'hF;
    #4;
    chk("bw_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("bw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("bw_mem_addr", {20'd0, mem_addr}, 32'h004);
    chk("bw_mem_wmask", {28'd0, mem_wmask}, 32'hF);
    chk("bw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    b_req = 1'b0; b_we = 1'b0; b_wmask = 4'h0;
    #4;
    chk("bw_ack_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("bw_ack_rdata", b_rdata, 32'd0);
    chk("bw_ack_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    tick();

    // Leave BOOT, fetch reads back the loaded word.
    boot_done = 1'b1;
    #4;
    chk("bd_still_boot", {31'd0, boot_state}, 32'd1);
    tick();
    boot_done = 1'b0;
    a_req = 1'b1; a_addr = 12'h004;
    #4;
    chk("run_boot_state", {31'd0, boot_state}, 32'd0);
    chk("ar_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("ar_mem_req", {31'd0, mem_req}, 32'd1);
    chk("ar_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ar_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    tick();
    a_req = 1'b0;
    #4;
    chk("ar_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("ar_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("ar_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    tick();

    // Contention: A,A,A,A,B repeating.
    a_req = 1'b1; a_addr = 12'h001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002;
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("streak_a_gnt", {31'd0, a_gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
      chk("streak_b_gnt", {31'd0, b_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // Alternating reads: data returns to the right port only.
    for (int r = 0; r < 2; r++) begin
      a_req = 1'b1; a_addr = 12'h001;
      #4;
      chk("alt_a_gnt", {31'd0, a_gnt}, 32'd1);
      tick();
      a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002;
      #4;
      chk("alt_b_gnt", {31'd0, b_gnt}, 32'd1);
      chk("alt_a_rvalid", {31'd0, a_rvalid}, 32'd1);
      chk("alt_a_rdata", a_rdata, 32'h1111_1111);
      chk("alt_b_rvalid0", {31'd0, b_rvalid}, 32'd0);
      chk("alt_b_rdata0", b_rdata, 32'd0);
      tick();
      b_req = 1'b0;
      #4;
      chk("alt_b_rvalid", {31'd0, b_rvalid}, 32'd1);
      chk("alt_b_rdata", b_rdata, 32'h2222_2222);
      chk("alt_a_rvalid0", {31'd0, a_rvalid}, 32'd0);
      chk("alt_a_rdata0", a_rdata, 32'd0);
      tick();
    end

    // Reset the cycle after an A read grant drops the return.
    a_req = 1'b1; a_addr = 12'h001;
    #4;
    chk("rd_drop_gnt", {31'd0, a_gnt}, 32'd1);
    tick();
    a_req = 1'b0; reset = 1'b1;
    #4;
    chk("rd_drop_rvalid", {31'd0, a_rvalid}, 32'd0);
    tick();
    reset = 1'b0;
    #4;
    chk("rd_drop_rvalid2", {31'd0, a_rvalid}, 32'd0);
    chk("rd_drop_boot", {31'd0, boot_state}, 32'd1);
    chk("rd_drop_err", {31'd0, err}, 32'd0);
    tick();

    // Spurious mem_rvalid sets a sticky error.
    inj = 1'b1;
    #4;
    chk("inj_no_fwd", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    tick();
    inj = 1'b0;
    #4;
    chk("err_set", {31'd0, err}, 32'd1);
    tick(); tick();
    #4;
    chk("err_sticky", {31'd0, err}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #4;
    chk("err_cleared", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
